spi_cmd_decoder: RTL

Consumes the 24-bit frames assembled by the SPI byte receiver (1-cycle valid pulse per 3-byte frame) and decodes each one as a register command. Commands are applied to a shadow register bank. The shadow bank is copied to the active bank, which drives the video pipeline, only on the vsync strobe following a COMMIT command. This gives tear-free reconfiguration.

---
 rtl/spi_cmd_decoder_pkg.sv | 29 ++
 rtl/spi_cmd_shadow_bank.sv | 69 ++++++
 rtl/spi_cmd_decoder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spi_cmd_pkg
// Description : Shared widths, opcode encodings and decoder state encoding
//               for the SPI register-command decoder.
// Contents    : FRAME_W/DATA_W/ADDR_W widths, OP_* opcodes, IDLE/EXEC states.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

  localparam int FRAME_W = 24;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 3;

  localparam logic [OP_W-1:0] OP_NOP        = 3'b000;
  localparam logic [OP_W-1:0] OP_WRITE      = 3'b001;
  localparam logic [OP_W-1:0] OP_SET        = 3'b010;
  localparam logic [OP_W-1:0] OP_CLEAR      = 3'b011;
  localparam logic [OP_W-1:0] OP_COMMIT     = 3'b100;
  localparam logic [OP_W-1:0] OP_CLR_STATUS = 3'b101;
  localparam logic [OP_W-1:0] OP_READ       = 3'b110;

  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] IDLE = 1'b0;
  localparam logic [STATE_W-1:0] EXEC = 1'b1;

endpackage : spi_cmd_pkg
`default_nettype wire

// File: rtl/spi_cmd_shadow_bank.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_shadow_bank
// Description : Shadow and active register banks. The shadow bank takes one
//               write per cycle; the whole shadow bank is copied into the
//               active bank when commit is high.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               we/addr/wdata   - shadow write port (addr must be < NUM_REGS)
//               raddr/rdata     - combinational shadow read port
//               commit          - copy shadow -> active this cycle
//               active_flat     - registered active bank, reg i at [16i+:16]
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_shadow_bank
  import spi_cmd_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] REG_RESET = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [ADDR_W-1:0]            raddr,
  output logic [DATA_W-1:0]            rdata,
  input  logic                         commit,
  output logic [NUM_REGS*DATA_W-1:0]   active_flat
);

  logic [NUM_REGS*DATA_W-1:0] shadow_flat;

  // One register pair per slot; the commit copy reads the shadow value from
  // before any write in the same cycle.
  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic [DATA_W-1:0] shadow_q;
      logic [DATA_W-1:0] active_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= REG_RESET;
          active_q <= REG_RESET;
        end else begin
          if (we && (addr == ADDR_W'(i))) begin
            shadow_q <= wdata;
          end
          if (commit) begin
            active_q <= shadow_q;
          end
        end
      end

      assign shadow_flat[i*DATA_W +: DATA_W] = shadow_q;
      assign active_flat[i*DATA_W +: DATA_W] = active_q;
    end
  endgenerate

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rdata = shadow_flat[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule : spi_cmd_shadow_bank
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder
// Description : Decodes 24-bit SPI frames {op[2:0], addr[4:0], data[15:0]}
//               into register commands on a shadow bank. The shadow bank is
//               copied to the active bank (regs_out) on the first vsync
//               strobe after a COMMIT, giving tear-free reconfiguration.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               frame_in          - received frame, valid with frame_valid
//               frame_valid       - 1-cycle frame strobe
//               vsync_strobe      - 1-cycle start-of-vblank strobe
//               regs_out          - active bank, reg i at [16i+15:16i]
//               busy              - high in the EXEC cycle
//               commit_pending    - COMMIT accepted, not yet applied
//               commit_done       - pulse while regs_out shows a new commit
//               err_count         - saturating illegal-op / bad-addr count
//               overrun           - sticky: frame arrived while busy
//               rd_data, rd_valid - readback (SPI_CMD_READBACK_EN only)
// Options     : SPI_CMD_READBACK_EN - enables op 110 (READ) and rd_* ports;
//               when undefined op 110 is counted as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] REG_RESET = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FRAME_W-1:0]          frame_in,
  input  logic                        frame_valid,
  input  logic                        vsync_strobe,
  output logic [NUM_REGS*DATA_W-1:0]  regs_out,
  output logic                        busy,
  output logic                        commit_pending,
  output logic                        commit_done,
  output logic [7:0]                  err_count,
  output logic                        overrun
`ifdef SPI_CMD_READBACK_EN
  ,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid
`endif
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [FRAME_W-1:0] frame_q;

  logic [OP_W-1:0]    op;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data;
  logic               addr_ok;
  logic               exec;

  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  shadow_rdata;
  logic               err_inc;
  logic               do_commit;
  logic               do_clr;
  logic               overrun_set;
  logic               commit_now;
`ifdef SPI_CMD_READBACK_EN
  logic               do_read;
`endif

  assign op   = frame_q[FRAME_W-1 -: OP_W];
  assign addr = frame_q[DATA_W +: ADDR_W];
  assign data = frame_q[DATA_W-1:0];
  assign addr_ok = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
  assign exec = (state_q == EXEC);

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_valid) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == EXEC);
  end

  // Frame is captured only from IDLE; a frame seen in EXEC is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if ((state_q == IDLE) && frame_valid) begin
      frame_q <= frame_in;
    end
  end

  // --------------------------------------------------------------------------
  // Command decode (active only in EXEC)
  // --------------------------------------------------------------------------
  always_comb begin
    wr_en     = 1'b0;
    wr_data   = shadow_rdata;
    err_inc   = 1'b0;
    do_commit = 1'b0;
    do_clr    = 1'b0;
`ifdef SPI_CMD_READBACK_EN
    do_read   = 1'b0;
`endif
    if (exec) begin
      case (op)
        OP_NOP: ;
        OP_WRITE: begin
          if (addr_ok) begin
            wr_en   = 1'b1;
            wr_data = data;
          end else begin
            err_inc = 1'b1;
          end
        end
        OP_SET: begin
          if (addr_ok) begin
            wr_en   = 1'b1;
            wr_data = shadow_rdata | data;
          end else begin
            err_inc = 1'b1;
          end
        end
        OP_CLEAR: begin
          if (addr_ok) begin
            wr_en   = 1'b1;
            wr_data = shadow_rdata & ~data;
          end else begin
            err_inc = 1'b1;
          end
        end
        OP_COMMIT:     do_commit = 1'b1;
        OP_CLR_STATUS: do_clr    = 1'b1;
`ifdef SPI_CMD_READBACK_EN
        OP_READ: begin
          if (addr_ok) begin
            do_read = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
`endif
        default: err_inc = 1'b1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status and commit control
  // --------------------------------------------------------------------------
  assign overrun_set = frame_valid && (state_q == EXEC);
  // Uses the registered flag, so a strobe in the EXEC cycle of the COMMIT
  // itself does not apply; it waits for the next strobe.
  assign commit_now  = vsync_strobe && commit_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count      <= 8'd0;
      overrun        <= 1'b0;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
    end else begin
      if (do_clr) begin
        err_count <= 8'd0;
      end else if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      // A coincident overrun beats CLR_STATUS.
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (do_clr) begin
        overrun <= 1'b0;
      end

      // A new COMMIT in the same cycle as an applied commit stays pending.
      if (do_commit) begin
        commit_pending <= 1'b1;
      end else if (commit_now) begin
        commit_pending <= 1'b0;
      end

      // Aligned with the cycle regs_out first shows the committed values.
      commit_done <= commit_now;
    end
  end

`ifdef SPI_CMD_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_read;
      if (do_read) begin
        rd_data <= shadow_rdata;
      end
    end
  end
`endif

  spi_cmd_shadow_bank #(
    .NUM_REGS  (NUM_REGS),
    .REG_RESET (REG_RESET)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .we          (wr_en),
    .addr        (addr),
    .wdata       (wr_data),
    .raddr       (addr),
    .rdata       (shadow_rdata),
    .commit      (commit_now),
    .active_flat (regs_out)
  );

endmodule : spi_cmd_decoder
`default_nettype wire
